// File: rtl/layer_fold_scheduler.sv
// Layer sequencer: steps through every row/col fold of each layer, hands tiles to the
// systolic array one at a time, runs pooling when enabled and advances layer by layer.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for net_start
// KICK      | first layer_switch_signal pulse of a run
// WAIT_CFG  | waiting for start_cal_folding_flag from the config bank
// LOAD      | config settling; latch fold sizes/pooling/layer at exit
// ISSUE     | tile_start pulse with current fold indices
// WAIT_TILE | waiting for tile_done, then advance row (inner) / col (outer)
// GAP       | array drain cycles between tiles
// POOL      | pool_start pulse
// WAIT_POOL | waiting for pool_done
// SWITCH    | layer_switch_signal pulse; ends network after last layer
// DONE      | net_done pulse
module layer_fold_scheduler #(
    parameter int NUM_LAYERS = 5,
    parameter int TILE_GAP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        net_start,
    input  logic        start_cal_folding_flag,
    input  logic [7:0]  FOLD_ROWS,
    input  logic [7:0]  FOLD_COLS,
    input  logic        pooling_en,
    input  logic [3:0]  layer_index,
    input  logic        tile_done,
    input  logic        pool_done,
    output logic        layer_switch_signal,
    output logic        tile_start,
    output logic [7:0]  fold_row_idx,
    output logic [7:0]  fold_col_idx,
    output logic        pool_start,
    output logic        busy,
    output logic        net_done,
    output logic [15:0] tile_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_KICK, S_WAIT_CFG, S_LOAD, S_ISSUE, S_WAIT_TILE,
        S_GAP, S_POOL, S_WAIT_POOL, S_SWITCH, S_DONE
    } state_t;

    localparam logic [3:0] GAP_LOAD = (TILE_GAP > 0) ? 4'(TILE_GAP - 1) : 4'd0;

    state_t      state, state_nxt;
    logic [7:0]  rows_lat, cols_lat;
    logic        pool_lat;
    logic [3:0]  layer_lat;
    logic [7:0]  row_cnt, col_cnt, row_nxt, col_nxt;
    logic [3:0]  gap_cnt;
    logic        last_row, last_tile;

    logic        layer_switch_d, tile_start_d, pool_start_d, busy_d, net_done_d;
    logic [7:0]  fold_row_d, fold_col_d;
    logic [15:0] tile_count_d;

    assign last_row  = (row_cnt == rows_lat);
    assign last_tile = last_row && (col_cnt == cols_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            layer_switch_signal <= 1'b0;
            tile_start          <= 1'b0;
            fold_row_idx        <= 8'd0;
            fold_col_idx        <= 8'd0;
            pool_start          <= 1'b0;
            busy                <= 1'b0;
            net_done            <= 1'b0;
            tile_count          <= 16'd0;
        end else begin
            state               <= state_nxt;
            layer_switch_signal <= layer_switch_d;
            tile_start          <= tile_start_d;
            fold_row_idx        <= fold_row_d;
            fold_col_idx        <= fold_col_d;
            pool_start          <= pool_start_d;
            busy                <= busy_d;
            net_done            <= net_done_d;
            tile_count          <= tile_count_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (net_start) state_nxt = S_KICK;
            S_KICK:      state_nxt = S_WAIT_CFG;
            S_WAIT_CFG:  if (start_cal_folding_flag) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_TILE;
            S_WAIT_TILE: begin
                if (tile_done) begin
                    if (last_tile)          state_nxt = pool_lat ? S_POOL : S_SWITCH;
                    else if (TILE_GAP == 0) state_nxt = S_ISSUE;
                    else                    state_nxt = S_GAP;
                end
            end
            S_GAP:       if (gap_cnt == 4'd0) state_nxt = S_ISSUE;
            S_POOL:      state_nxt = S_WAIT_POOL;
            S_WAIT_POOL: if (pool_done) state_nxt = S_SWITCH;
            S_SWITCH:    state_nxt = (layer_lat == 4'(NUM_LAYERS)) ? S_DONE : S_WAIT_CFG;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Counter values for the next cycle, so a tile issued right after tile_done sees them.
    always_comb begin
        row_nxt = row_cnt;
        col_nxt = col_cnt;
        if (state == S_LOAD) begin
            row_nxt = 8'd0;
            col_nxt = 8'd0;
        end else if (state == S_WAIT_TILE && tile_done && !last_tile) begin
            if (last_row) begin
                row_nxt = 8'd0;
                col_nxt = col_cnt + 8'd1;
            end else begin
                row_nxt = row_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        layer_switch_d = (state_nxt == S_KICK) || (state_nxt == S_SWITCH);
        tile_start_d   = (state_nxt == S_ISSUE);
        pool_start_d   = (state_nxt == S_POOL);
        net_done_d     = (state_nxt == S_DONE);
        busy_d         = (state_nxt != S_IDLE);
        fold_row_d     = tile_start_d ? row_nxt : fold_row_idx;
        fold_col_d     = tile_start_d ? col_nxt : fold_col_idx;
        tile_count_d   = tile_count;
        if (state == S_IDLE && net_start)
            tile_count_d = 16'd0;
        else if (tile_start_d && tile_count != 16'hFFFF)
            tile_count_d = tile_count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_lat  <= 8'd0;
            cols_lat  <= 8'd0;
            pool_lat  <= 1'b0;
            layer_lat <= 4'd0;
            row_cnt   <= 8'd0;
            col_cnt   <= 8'd0;
            gap_cnt   <= 4'd0;
        end else begin
            row_cnt <= row_nxt;
            col_cnt <= col_nxt;
            if (state == S_LOAD) begin
                rows_lat  <= FOLD_ROWS;
                cols_lat  <= FOLD_COLS;
                pool_lat  <= pooling_en;
                layer_lat <= layer_index;
            end
            if (state_nxt == S_GAP && state != S_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;
        end
    end

endmodule
